scene_compositor: RTL

Parametrised pixel compositor and game-state sequencer between the per-object renderers (ball, paddles, bricks, score) and the HDMI transmitter. Merges N layers by priority or bitwise-OR through a 2-stage pipeline and reports per-frame overlap flags. Runs the RUN/OVER state machine that holds the game logic in reset and paints a full-screen overlay for a fixed number of frames after an end-of-game request.

---
 rtl/scene_compositor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/scene_compositor.sv
// rtl/scene_compositor.sv - layer compositor with overlap flags and RUN/OVER game-state sequencer
module scene_compositor #(
    parameter int          NUM_LAYERS     = 4,
    parameter int          BLEND_MODE     = 0,
    parameter int          OVERLAY_FRAMES = 120,
    parameter logic [23:0] BG_COLOR       = 24'h000000,
    parameter logic [23:0] OVERLAY_COLOR  = 24'hFF0000
) (
    input  logic                       pixel_clk,
    input  logic                       rst,
    input  logic                       fsync,
    input  logic                       active,
    input  logic [NUM_LAYERS-1:0]      layer_active,
    input  logic [24*NUM_LAYERS-1:0]   layer_pixel,
    input  logic                       end_req,
    output logic [23:0]                pix_out,
    output logic                       active_out,
    output logic                       fsync_out,
    output logic                       game_over,
    output logic [NUM_LAYERS-1:0]      overlap
);

    localparam int CW = $clog2(OVERLAY_FRAMES + 1);
    localparam logic [NUM_LAYERS-1:0] LAYER_ONE = NUM_LAYERS'(1);

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

    state_t                state;
    logic [CW-1:0]         frame_cnt;

    logic [23:0]           merged;
    logic                  any_layer;
    logic                  multi_layer;
    logic [NUM_LAYERS-1:0] contrib;
    logic [NUM_LAYERS-1:0] acc;

    logic [23:0]           s1_pix;
    logic                  s1_any;
    logic                  s1_active;
    logic                  s1_fsync;
    logic                  s1_over;

    // Merge the active layers: lowest index wins, or OR of all active layers
    always_comb begin
        merged = '0;
        if (BLEND_MODE == 0) begin
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (layer_active[i]) begin
                    merged = layer_pixel[24*i +: 24];
                end
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (layer_active[i]) begin
                    merged = merged | layer_pixel[24*i +: 24];
                end
            end
        end
    end

    // Overlap detection: clearing the lowest set bit leaves something only when two or more bits are set
    always_comb begin
        any_layer   = |layer_active;
        multi_layer = |(layer_active & (layer_active - LAYER_ONE));
        contrib     = (active && multi_layer) ? layer_active : '0;
    end

    // Stage 1: register the merge result together with the qualifiers and the state it was seen in
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s1_pix    <= '0;
            s1_any    <= 1'b0;
            s1_active <= 1'b0;
            s1_fsync  <= 1'b0;
            s1_over   <= 1'b0;
        end else begin
            s1_pix    <= merged;
            s1_any    <= any_layer;
            s1_active <= active;
            s1_fsync  <= fsync;
            s1_over   <= (state == OVER);
        end
    end

    // Stage 2: choose black, overlay, background or merged colour
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pix_out    <= '0;
            active_out <= 1'b0;
            fsync_out  <= 1'b0;
        end else begin
            active_out <= s1_active;
            fsync_out  <= s1_fsync;
            if (!s1_active) begin
                pix_out <= 24'h000000;
            end else if (s1_over) begin
                pix_out <= OVERLAY_COLOR;
            end else if (s1_any) begin
                pix_out <= s1_pix;
            end else begin
                pix_out <= BG_COLOR;
            end
        end
    end

    // Per-frame overlap accumulator; the fsync cycle publishes the old frame and seeds the new one
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            acc     <= '0;
            overlap <= '0;
        end else if (fsync) begin
            overlap <= acc;
            acc     <= contrib;
        end else begin
            acc     <= acc | contrib;
        end
    end

    // RUN/OVER sequencer: end_req enters OVER, OVERLAY_FRAMES fsyncs later back to RUN
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state     <= RUN;
            frame_cnt <= '0;
            game_over <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (end_req) begin
                        state     <= OVER;
                        frame_cnt <= '0;
                        game_over <= 1'b1;
                    end
                end
                OVER: begin
                    if (fsync) begin
                        if (frame_cnt == CW'(OVERLAY_FRAMES - 1)) begin
                            state     <= RUN;
                            frame_cnt <= '0;
                            game_over <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state     <= RUN;
                    frame_cnt <= '0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
